ram_access_arbiter: RTL and testbench

//  Shares one ram_module between two requesters (A: UART-side, B: RF-side) with round-robin arbitration.

---
 rtl/ram_access_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one edge-triggered ram_module between requesters A and B.
// Turns held requests into rd_ins/wr_ins strobes, tracks the flag handshake and returns a one-cycle ack.
module ram_access_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int STROBE_TMO    = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr_rd,
    output logic [ADDR_WIDTH-1:0] ram_addr_wr,
    output logic [DATA_WIDTH-1:0] ram_data_wr,
    output logic                  ram_rd_ins,
    output logic                  ram_wr_ins,
    input  logic [DATA_WIDTH-1:0] ram_data_rd,
    input  logic                  ram_flag_rd,
    input  logic                  ram_flag_wr
);

    typedef enum logic [2:0] {INIT_RD, IDLE, STROBE, WAIT_DONE, SETTLE, ACK} state_t;

    localparam int CNT_MAX = (STROBE_TMO > SETTLE_CYCLES) ? STROBE_TMO : SETTLE_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(STROBE_TMO - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic                  init_wait, init_wait_d;
    logic                  op_we, op_we_d;
    logic                  op_b, op_b_d;
    logic                  rr_prio_b, rr_prio_b_d;
    logic                  err_pend, err_pend_d;
    logic [ADDR_WIDTH-1:0] addr_rd_d, addr_wr_d;
    logic [DATA_WIDTH-1:0] data_wr_d, rdata_d;
    logic                  rd_ins_d, wr_ins_d, a_ack_d, b_ack_d, err_d;
    logic                  grant_b, flag_op;

    assign busy    = (state != IDLE);
    assign grant_b = b_req && (!a_req || rr_prio_b);
    assign flag_op = op_we ? ram_flag_wr : ram_flag_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT_RD;
            cnt         <= '0;
            init_wait   <= 1'b0;
            op_we       <= 1'b0;
            op_b        <= 1'b0;
            rr_prio_b   <= 1'b0;
            err_pend    <= 1'b0;
            ram_addr_rd <= '0;
            ram_addr_wr <= '0;
            ram_data_wr <= '0;
            ram_rd_ins  <= 1'b0;
            ram_wr_ins  <= 1'b0;
            rdata       <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            init_wait   <= init_wait_d;
            op_we       <= op_we_d;
            op_b        <= op_b_d;
            rr_prio_b   <= rr_prio_b_d;
            err_pend    <= err_pend_d;
            ram_addr_rd <= addr_rd_d;
            ram_addr_wr <= addr_wr_d;
            ram_data_wr <= data_wr_d;
            ram_rd_ins  <= rd_ins_d;
            ram_wr_ins  <= wr_ins_d;
            rdata       <= rdata_d;
            a_ack       <= a_ack_d;
            b_ack       <= b_ack_d;
            err         <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        init_wait_d = init_wait;
        op_we_d     = op_we;
        op_b_d      = op_b;
        rr_prio_b_d = rr_prio_b;
        err_pend_d  = err_pend;
        addr_rd_d   = ram_addr_rd;
        addr_wr_d   = ram_addr_wr;
        data_wr_d   = ram_data_wr;
        rd_ins_d    = ram_rd_ins;
        wr_ins_d    = ram_wr_ins;
        rdata_d     = rdata;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        err_d       = 1'b0;

        case (state)
            // Dummy read of address 0; its data is discarded and rdata is left untouched.
            INIT_RD: begin
                if (!init_wait) begin
                    rd_ins_d  = 1'b1;
                    addr_rd_d = '0;
                    if (ram_rd_ins) begin
                        if (!ram_flag_rd) begin
                            rd_ins_d    = 1'b0;
                            init_wait_d = 1'b1;
                            cnt_d       = '0;
                        end else if (cnt == TMO_LAST) begin
                            rd_ins_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt + CW'(1);
                        end
                    end
                end else if (ram_flag_rd) begin
                    init_wait_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (a_req || b_req) begin
                    op_b_d     = grant_b;
                    op_we_d    = grant_b ? b_we : a_we;
                    cnt_d      = '0;
                    err_pend_d = 1'b0;
                    state_d    = STROBE;
                    if (grant_b ? b_we : a_we) begin
                        addr_wr_d = grant_b ? b_addr : a_addr;
                        data_wr_d = grant_b ? b_wdata : a_wdata;
                        wr_ins_d  = 1'b1;
                    end else begin
                        addr_rd_d = grant_b ? b_addr : a_addr;
                        rd_ins_d  = 1'b1;
                    end
                end
            end
            STROBE: begin
                if (!flag_op) begin
                    rd_ins_d = 1'b0;
                    wr_ins_d = 1'b0;
                    state_d  = WAIT_DONE;
                end else if (cnt == TMO_LAST) begin
                    // RAM never answered: give up and ack with an error.
                    rd_ins_d   = 1'b0;
                    wr_ins_d   = 1'b0;
                    err_pend_d = 1'b1;
                    a_ack_d    = !op_b;
                    b_ack_d    = op_b;
                    err_d      = 1'b1;
                    state_d    = ACK;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (flag_op) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    if (!op_we) rdata_d = ram_data_rd;
                    a_ack_d = !op_b;
                    b_ack_d = op_b;
                    err_d   = err_pend;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ACK: begin
                rr_prio_b_d = !op_b;
                cnt_d       = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a small behavioural ram_module model.
module tb_ram_access_arbiter;
    logic       clk = 0, rst_n = 0;
    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [8:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic       a_ack, b_ack, err, busy, ram_rd_ins, ram_wr_ins;
    logic [7:0] rdata, ram_data_wr;
    logic [8:0] ram_addr_rd, ram_addr_wr;
    logic [7:0] ram_data_rd;
    logic       ram_flag_rd, ram_flag_wr;
    logic       stuck_wr = 0;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    ram_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .err(err), .busy(busy),
        .ram_addr_rd(ram_addr_rd), .ram_addr_wr(ram_addr_wr), .ram_data_wr(ram_data_wr),
        .ram_rd_ins(ram_rd_ins), .ram_wr_ins(ram_wr_ins),
        .ram_data_rd(ram_data_rd), .ram_flag_rd(ram_flag_rd), .ram_flag_wr(ram_flag_wr)
    );

    // RAM model: rising strobe -> flag drops 2 cycles later, returns 2 cycles after that.
    logic [7:0] mem [512];
    int   rd_t, wr_t;
    logic rd_q, wr_q;
    initial for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_flag_rd <= 1; ram_flag_wr <= 1; ram_data_rd <= 0;
            rd_t <= 0; wr_t <= 0; rd_q <= 0; wr_q <= 0;
        end else begin
            rd_q <= ram_rd_ins;
            wr_q <= ram_wr_ins;
            if (ram_rd_ins && !rd_q && rd_t == 0) rd_t <= 1;
            else if (rd_t != 0) begin
                rd_t <= rd_t + 1;
                if (rd_t == 2) begin ram_flag_rd <= 0; ram_data_rd <= mem[ram_addr_rd]; end
                if (rd_t == 4) begin ram_flag_rd <= 1; rd_t <= 0; end
            end
            if (ram_wr_ins && !wr_q && wr_t == 0 && !stuck_wr) wr_t <= 1;
            else if (wr_t != 0) begin
                wr_t <= wr_t + 1;
                if (wr_t == 2) begin ram_flag_wr <= 0; mem[ram_addr_wr] <= ram_data_wr; end
                if (wr_t == 4) begin ram_flag_wr <= 1; wr_t <= 0; end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Watches the post-reset dummy read until busy falls.
    task automatic init_check(input string tag);
        int rises = 0, acks = 0, bad_addr = 0;
        logic prev = 0, done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (ram_rd_ins && !prev) rises++;
            if (ram_rd_ins && ram_addr_rd != 0) bad_addr++;
            if (a_ack || b_ack) acks++;
            prev = ram_rd_ins;
            if (!busy) done = 1;
        end
        check({tag, "_busy_fell"}, done, 1);
        check({tag, "_rd_pulses"}, rises, 1);
        check({tag, "_addr0"}, bad_addr, 0);
        check({tag, "_no_ack"}, acks, 0);
    endtask

    task automatic do_op(input string tag, input bit b, input bit we, input logic [8:0] ad,
                         input logic [7:0] wd, output logic [7:0] rd, output logic e,
                         output int hi_wr);
        logic got = 0;
        rd = 0; e = 0; hi_wr = 0;
        @(negedge clk);
        if (b) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
        else   begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (ram_wr_ins) hi_wr++;
            if (b ? b_ack : a_ack) begin got = 1; rd = rdata; e = err; end
        end
        a_req = 0; b_req = 0;
        check({tag, "_ack"}, got, 1);
    endtask

    logic [7:0] rd;
    logic       e;
    int         hw;
    int         seq[$];
    logic [7:0] ra, rb;

    initial begin
        #12;
        check("rst_busy", busy, 1);
        check("rst_strobes", {ram_rd_ins, ram_wr_ins, a_ack, b_ack, err}, 0);
        @(negedge clk); rst_n = 1;
        init_check("init");

        do_op("wr1a5", 0, 1, 9'h1A5, 8'h3C, rd, e, hw);
        check("wr1a5_err", e, 0);
        check("wr1a5_rdata_kept", rd, 8'h00);
        do_op("rd1a5", 0, 0, 9'h1A5, 8'h00, rd, e, hw);
        check("rd1a5_data", rd, 8'h3C);
        check("rd1a5_err", e, 0);
        do_op("b_rd1a5", 1, 0, 9'h1A5, 8'h00, rd, e, hw);
        check("b_rd1a5_data", rd, 8'h3C);

        // Simultaneous requests, last grant was B so A wins the tie.
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 9'd5; a_wdata = 8'h11;
        b_req = 1; b_we = 0; b_addr = 9'd5;
        seq.delete();
        for (int i = 0; i < 200 && seq.size() < 2; i++) begin
            @(negedge clk);
            if (a_ack) begin seq.push_back(0); ra = rdata; a_req = 0; end
            if (b_ack) begin seq.push_back(1); rb = rdata; b_req = 0; end
        end
        a_req = 0; b_req = 0;
        check("tie_count", seq.size(), 2);
        if (seq.size() == 2) begin
            check("tie_first_A", seq[0], 0);
            check("tie_second_B", seq[1], 1);
            check("tie_A_rdata_kept", ra, 8'h3C);
            check("tie_B_rdata", rb, 8'h11);
        end

        // Continuous requests from both sides: grants must alternate starting with A.
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 9'h20; a_wdata = 8'h55;
        b_req = 1; b_we = 0; b_addr = 9'h1A5;
        seq.delete();
        begin
            int na = 0, nb = 0;
            for (int i = 0; i < 500 && (na < 4 || nb < 4); i++) begin
                @(negedge clk);
                if (a_ack) begin seq.push_back(0); na++; if (na == 4) a_req = 0; end
                if (b_ack) begin seq.push_back(1); rb = rdata; nb++; if (nb == 4) b_req = 0; end
            end
        end
        a_req = 0; b_req = 0;
        check("alt_count", seq.size(), 8);
        for (int i = 0; i < seq.size() && i < 8; i++)
            check($sformatf("alt_grant%0d", i), seq[i], i % 2);
        check("alt_B_rdata", rb, 8'h3C);

        // Stuck RAM write side: strobe held for exactly the timeout, then ack with err.
        stuck_wr = 1;
        do_op("stuck", 0, 1, 9'h0F0, 8'hAA, rd, e, hw);
        stuck_wr = 0;
        check("stuck_wr_high", hw, 7);
        check("stuck_err", e, 1);
        do_op("post_stuck_rd", 0, 0, 9'h1A5, 8'h00, rd, e, hw);
        check("post_stuck_err", e, 0);
        check("post_stuck_data", rd, 8'h3C);

        // Reset while the read waits for the flag to come back.
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 9'h1A5;
        begin
            logic seen_hi = 0, in_wait = 0;
            for (int i = 0; i < 50 && !in_wait; i++) begin
                @(negedge clk);
                if (ram_rd_ins) seen_hi = 1;
                else if (seen_hi && busy) in_wait = 1;
            end
            check("wait_done_reached", in_wait, 1);
        end
        #2 rst_n = 0;
        #1;
        check("mid_rst_busy", busy, 1);
        check("mid_rst_ctrl", {ram_rd_ins, ram_wr_ins, a_ack, b_ack, err}, 0);
        check("mid_rst_addr", {ram_addr_rd, ram_addr_wr, ram_data_wr}, 0);
        check("mid_rst_rdata", rdata, 0);
        a_req = 0;
        @(negedge clk); rst_n = 1;
        init_check("reinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
